data_memory_sync: RTL and testbench
===================================

// Module: data_memory_sync
// PURPOSE
//   Clocked, byte-addressable, little-endian data memory for the MEM stage.
//   Supports byte (lb/lbu/sb) and 16-bit word (lw/sw) accesses via a req/done handshake.
//   Misaligned word accesses split into two byte cycles; out-of-range accesses are flagged.
//   Contents are rebuilt by a sequential init sweep after every reset.
// PARAMETERS
//   ADDR_W   16    byte-address width
//   DEPTH    1024  memory size in bytes (>=16, <=2**ADDR_W)
// PORTS
//   clk         in   1       rising-edge clock
//   reset       in   1       synchronous, active-low reset
//   req         in   1       access request; accepted only when ready=1
//   mem_write   in   1       1=store, 0=load (sampled with req)
//   byte_en     in   1       1=byte access, 0=16-bit word access
//   sign_ext    in   1       byte loads only: 1=sign-extend (lb), 0=zero-extend (lbu)
//   address     in   ADDR_W  byte address
//   write_data  in   16      store data; byte stores use [7:0]
//   ready       out  1       block can accept req this cycle
//   done        out  1       one-cycle pulse: access complete
//   err         out  1       valid with done: address out of range
//   read_data   out  16      load result, valid with done (held until next done)
// BEHAVIOUR
//   Reset (reset=0 at clk edge): state<=INIT, init_cnt<=0, ready=0, done=0, err=0,
//     read_data=16'h0000. Any in-flight access is aborted; no further bytes written.
//   States: INIT -> IDLE <-> SECOND.
//   INIT: one byte per cycle, mem[init_cnt]<=image(init_cnt), init_cnt++; after
//     DEPTH cycles -> IDLE. image(0..9) = 56 38 00 00 12 43 DE BE EF AD; all others 00.
//     req ignored (ready=0).
//   IDLE: ready=1. On req at edge k, sample all inputs:
//     - range check: last = address + (byte_en ? 0 : 1); last >= DEPTH -> err.
//       No wrap-around (0xFFFF word access is out of range).
//       No memory update; done=1, err=1, read_data=0 in cycle k+1.
//     - byte, or word with address[0]=0: single cycle. Store writes mem[a]
//       (and mem[a+1]<=wd[15:8] for word). Load: word={mem[a+1],mem[a]};
//       byte={8{sign_ext&mem[a][7]},mem[a]}. done=1 in cycle k+1, stay IDLE;
//       back-to-back requests accepted every cycle.
//     - word, address[0]=1: edge k accesses mem[a] (low byte) -> SECOND.
//   SECOND: ready=0, new req ignored. Edge k+1 accesses mem[a+1] (high byte)
//     -> IDLE; done=1 in cycle k+2 with full word. Latency 2 vs 1.
//   Read-after-write: load accepted the cycle after a store to the same byte
//     returns the new value (store committed at its accept edge).
//   Stores produce done with read_data unchanged; err=0 whenever done=0.
//   Write data byte order: little-endian; wd[7:0] -> lowest address.
// TESTING
//   1. Release reset, count cycles -> ready rises exactly DEPTH cycles later;
//      word load 0x0004 -> read_data=16'h4312, done 1 cycle after accept.
//   2. Byte load 0x0007 sign_ext=0 -> 16'h00BE; sign_ext=1 -> 16'hFFBE;
//      byte load 0x0000 sign_ext=1 -> 16'h0056.
//   3. Word store 0x0101 <= 16'hA55A: ready low one cycle, done at k+2;
//      then word load 0x0101 -> 16'hA55A, byte 0x0101 -> 16'h005A, byte 0x0102 -> 16'h00A5.
//   4. Word load address DEPTH-1 -> done=1, err=1, read_data=0;
//      word store DEPTH-1 -> err=1 and mem[DEPTH-1] unchanged on byte reread.
//   5. Back-to-back: byte store 0x0020 <= 8'h7F, next cycle byte load 0x0020
//      -> 16'h007F; req during SECOND is ignored, with no done for it.
//   6. Assert reset in SECOND of misaligned store to 0x0031 -> outputs 0 next cycle,
//      re-init sweep runs, mem[0x0031]=00 and mem[0x0032]=00 afterwards.

Source files
------------

// File: rtl/data_memory_sync.sv
// rtl/data_memory_sync.sv - byte-addressable little-endian data memory with req/done handshake
// Word accesses on odd addresses take two cycles; contents are reloaded by a sweep after reset.
module data_memory_sync #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              mem_write,
  input  logic              byte_en,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] address,
  input  logic [15:0]       write_data,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic [15:0]       read_data
);

  localparam int               IDX_W    = $clog2(DEPTH);
  localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [7:0] IMAGE [16] = '{
    8'h56, 8'h38, 8'h00, 8'h00, 8'h12, 8'h43, 8'hDE, 8'hBE,
    8'hEF, 8'hAD, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_SECOND} state_t;

  logic [7:0]       mem [DEPTH];
  state_t           state;
  logic [IDX_W-1:0] init_cnt;
  logic [IDX_W-1:0] sec_idx;
  logic             sec_write;
  logic [7:0]       sec_byte;

  logic [ADDR_W:0]  last_addr;
  logic             oor;
  logic             split;
  logic [IDX_W-1:0] idx_lo;
  logic [IDX_W-1:0] idx_hi;
  logic [7:0]       rd_lo;
  logic [7:0]       rd_hi;
  logic [7:0]       rd_sec;
  logic [15:0]      load_val;
  logic [7:0]       img_byte;

  // Range check is done one bit wider than the address so 0xFFFF+1 cannot wrap.
  assign last_addr = {1'b0, address} + {{ADDR_W{1'b0}}, ~byte_en};
  assign oor       = last_addr >= DEPTH_X;
  assign split     = ~byte_en & address[0];
  assign idx_lo    = address[IDX_W-1:0];
  assign idx_hi    = idx_lo + IDX_W'(1);
  assign rd_lo     = mem[idx_lo];
  assign rd_hi     = mem[idx_hi];
  assign rd_sec    = mem[sec_idx];
  assign load_val  = byte_en ? {{8{sign_ext & rd_lo[7]}}, rd_lo} : {rd_hi, rd_lo};
  assign img_byte  = ((init_cnt >> 4) == '0) ? IMAGE[init_cnt[3:0]] : 8'h00;

  logic             we0;
  logic             we1;
  logic [IDX_W-1:0] wa0;
  logic [IDX_W-1:0] wa1;
  logic [7:0]       wd0;
  logic [7:0]       wd1;

  // Writes are gated by reset so an access interrupted by reset leaves no trace.
  always_comb begin
    we0 = 1'b0;
    we1 = 1'b0;
    wa0 = init_cnt;
    wd0 = img_byte;
    wa1 = idx_hi;
    wd1 = write_data[15:8];
    if (reset) begin
      case (state)
        S_INIT: we0 = 1'b1;
        S_IDLE: begin
          if (req && !oor && mem_write) begin
            we0 = 1'b1;
            wa0 = idx_lo;
            wd0 = write_data[7:0];
            we1 = ~byte_en & ~address[0];
          end
        end
        S_SECOND: begin
          if (sec_write) begin
            we0 = 1'b1;
            wa0 = sec_idx;
            wd0 = sec_byte;
          end
        end
        default: we0 = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (we0) mem[wa0] <= wd0;
    if (we1) mem[wa1] <= wd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_INIT;
      init_cnt  <= '0;
      ready     <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      read_data <= 16'h0000;
      sec_idx   <= '0;
      sec_write <= 1'b0;
      sec_byte  <= 8'h00;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_INIT: begin
          init_cnt <= init_cnt + IDX_W'(1);
          if (init_cnt == LAST_IDX) begin
            state <= S_IDLE;
            ready <= 1'b1;
          end
        end
        S_IDLE: begin
          if (req) begin
            if (oor) begin
              done      <= 1'b1;
              err       <= 1'b1;
              read_data <= 16'h0000;
            end else if (split) begin
              // sec_byte carries the pending high store byte or the already-read low load byte.
              state     <= S_SECOND;
              ready     <= 1'b0;
              sec_idx   <= idx_hi;
              sec_write <= mem_write;
              sec_byte  <= mem_write ? write_data[15:8] : rd_lo;
            end else begin
              done <= 1'b1;
              if (!mem_write) read_data <= load_val;
            end
          end
        end
        S_SECOND: begin
          state <= S_IDLE;
          ready <= 1'b1;
          done  <= 1'b1;
          if (!sec_write) read_data <= {rd_sec, sec_byte};
        end
        default: begin
          state <= S_INIT;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_sync.sv
// tb/tb_data_memory_sync.sv - self-checking bench for data_memory_sync
// Transaction-level reference model plus directed literal checks and random traffic.
module tb_data_memory_sync;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        mem_write;
  logic        byte_en;
  logic        sign_ext;
  logic [15:0] address;
  logic [15:0] write_data;
  logic        ready;
  logic        done;
  logic        err;
  logic [15:0] read_data;

  int checks = 0;
  int errors = 0;

  data_memory_sync #(.ADDR_W(16), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .mem_write  (mem_write),
    .byte_en    (byte_en),
    .sign_ext   (sign_ext),
    .address    (address),
    .write_data (write_data),
    .ready      (ready),
    .done       (done),
    .err        (err),
    .read_data  (read_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: whole transactions applied atomically to a byte array.
  logic [7:0]  mm [DEPTH];
  logic [7:0]  img [10] = '{8'h56, 8'h38, 8'h00, 8'h00, 8'h12, 8'h43, 8'hDE, 8'hBE, 8'hEF, 8'hAD};
  bit          model_on = 1'b0;
  int          init_left = 0;
  bit          busy = 1'b0;
  bit          p_write = 1'b0;
  logic [15:0] p_rd = 16'h0000;
  logic        exp_ready = 1'b0;
  logic        exp_done = 1'b0;
  logic        exp_err = 1'b0;
  logic [15:0] exp_rd = 16'h0000;

  always @(posedge clk) begin
    int a;
    int last;
    if (!reset) begin
      model_on  = 1'b1;
      init_left = DEPTH;
      busy      = 1'b0;
      exp_ready = 1'b0;
      exp_done  = 1'b0;
      exp_err   = 1'b0;
      exp_rd    = 16'h0000;
      for (int i = 0; i < DEPTH; i++) mm[i] = (i < 10) ? img[i] : 8'h00;
    end else if (model_on) begin
      exp_done = 1'b0;
      exp_err  = 1'b0;
      if (init_left > 0) begin
        init_left--;
      end else if (busy) begin
        busy     = 1'b0;
        exp_done = 1'b1;
        if (!p_write) exp_rd = p_rd;
      end else if (req) begin
        a    = int'(address);
        last = a + (byte_en ? 0 : 1);
        if (last >= DEPTH) begin
          exp_done = 1'b1;
          exp_err  = 1'b1;
          exp_rd   = 16'h0000;
        end else begin
          p_write = mem_write;
          if (mem_write) begin
            mm[a] = write_data[7:0];
            if (!byte_en) mm[a+1] = write_data[15:8];
          end else if (byte_en) begin
            p_rd = {{8{sign_ext & mm[a][7]}}, mm[a]};
          end else begin
            p_rd = {mm[a+1], mm[a]};
          end
          if (!byte_en && (a % 2 == 1)) begin
            busy = 1'b1;
          end else begin
            exp_done = 1'b1;
            if (!mem_write) exp_rd = p_rd;
          end
        end
      end
      exp_ready = (init_left == 0) && !busy;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("model_ready", 32'(ready), 32'(exp_ready));
      chk("model_done", 32'(done), 32'(exp_done));
      chk("model_err", 32'(err), 32'(exp_err));
      chk("model_rdata", 32'(read_data), 32'(exp_rd));
    end
  end

  task automatic wait_ready(input int limit);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("wait_ready", 32'(ready), 32'd1);
  endtask

  task automatic access(input logic w, input logic b, input logic s, input logic [15:0] a,
                        input logic [15:0] wd, output logic [15:0] rd, output logic e,
                        output int lat);
    wait_ready(20);
    mem_write  = w;
    byte_en    = b;
    sign_ext   = s;
    address    = a;
    write_data = wd;
    req        = 1'b1;
    @(negedge clk);
    req = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 5) begin
      @(negedge clk);
      lat++;
    end
    rd = read_data;
    e  = err;
  endtask

  initial begin
    logic [15:0] rd;
    logic        e;
    int          lat;
    int          n;

    reset = 1'b0; req = 1'b0; mem_write = 1'b0; byte_en = 1'b0; sign_ext = 1'b0;
    address = 16'h0000; write_data = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", 32'(ready), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_rdata", 32'(read_data), 32'h0);
    reset = 1'b1;
    n = 0;
    while (ready !== 1'b1 && n < DEPTH + 20) begin
      @(negedge clk);
      n++;
    end
    chk("init_cycles", 32'(n), 32'(DEPTH));

    access(1'b0, 1'b0, 1'b0, 16'h0004, 16'h0, rd, e, lat);
    chk("lw_0004", 32'(rd), 32'h4312);
    chk("lw_0004_lat", 32'(lat), 32'd1);

    access(1'b0, 1'b1, 1'b0, 16'h0007, 16'h0, rd, e, lat);
    chk("lbu_0007", 32'(rd), 32'h00BE);
    access(1'b0, 1'b1, 1'b1, 16'h0007, 16'h0, rd, e, lat);
    chk("lb_0007", 32'(rd), 32'hFFBE);
    access(1'b0, 1'b1, 1'b1, 16'h0000, 16'h0, rd, e, lat);
    chk("lb_0000", 32'(rd), 32'h0056);

    access(1'b1, 1'b0, 1'b0, 16'h0101, 16'hA55A, rd, e, lat);
    chk("sw_0101_lat", 32'(lat), 32'd2);
    access(1'b0, 1'b0, 1'b0, 16'h0101, 16'h0, rd, e, lat);
    chk("lw_0101", 32'(rd), 32'hA55A);
    chk("lw_0101_lat", 32'(lat), 32'd2);
    access(1'b0, 1'b1, 1'b0, 16'h0101, 16'h0, rd, e, lat);
    chk("lbu_0101", 32'(rd), 32'h005A);
    access(1'b0, 1'b1, 1'b0, 16'h0102, 16'h0, rd, e, lat);
    chk("lbu_0102", 32'(rd), 32'h00A5);

    access(1'b0, 1'b0, 1'b0, 16'(DEPTH - 1), 16'h0, rd, e, lat);
    chk("lw_oor_err", 32'(e), 32'd1);
    chk("lw_oor_rdata", 32'(rd), 32'h0);
    chk("lw_oor_lat", 32'(lat), 32'd1);
    access(1'b1, 1'b0, 1'b0, 16'(DEPTH - 1), 16'hBEEF, rd, e, lat);
    chk("sw_oor_err", 32'(e), 32'd1);
    access(1'b0, 1'b1, 1'b0, 16'(DEPTH - 1), 16'h0, rd, e, lat);
    chk("lbu_last_err", 32'(e), 32'd0);
    chk("lbu_last_keep", 32'(rd), 32'h0000);
    access(1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0, rd, e, lat);
    chk("lw_ffff_err", 32'(e), 32'd1);

    wait_ready(20);
    mem_write = 1'b1; byte_en = 1'b1; sign_ext = 1'b0; address = 16'h0020; write_data = 16'h127F;
    req = 1'b1;
    @(negedge clk);
    mem_write = 1'b0;
    @(negedge clk);
    req = 1'b0;
    chk("raw_done", 32'(done), 32'd1);
    chk("raw_rdata", 32'(read_data), 32'h007F);

    wait_ready(20);
    mem_write = 1'b0; byte_en = 1'b0; address = 16'h0005; req = 1'b1;
    @(negedge clk);
    chk("second_ready", 32'(ready), 32'd0);
    chk("second_done", 32'(done), 32'd0);
    byte_en = 1'b1; address = 16'h0000;
    @(negedge clk);
    req = 1'b0;
    chk("split_done", 32'(done), 32'd1);
    chk("split_rdata", 32'(read_data), 32'hDE43);
    @(negedge clk);
    chk("ignored_no_done", 32'(done), 32'd0);

    for (int i = 0; i < 600; i++) begin
      req        = ($urandom_range(0, 9) < 7);
      mem_write  = 1'($urandom_range(0, 1));
      byte_en    = 1'($urandom_range(0, 1));
      sign_ext   = 1'($urandom_range(0, 1));
      write_data = 16'($urandom());
      case ($urandom_range(0, 7))
        0:       address = 16'(DEPTH - 2 + $urandom_range(0, 3));
        1:       address = 16'hFFFE + 16'($urandom_range(0, 1));
        default: address = 16'($urandom_range(0, 63));
      endcase
      @(negedge clk);
    end
    req = 1'b0;
    repeat (3) @(negedge clk);

    wait_ready(20);
    mem_write = 1'b1; byte_en = 1'b0; address = 16'h0031; write_data = 16'h1234; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_ready", 32'(ready), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    chk("abort_rdata", 32'(read_data), 32'h0);
    reset = 1'b1;
    wait_ready(DEPTH + 20);
    access(1'b0, 1'b1, 1'b0, 16'h0031, 16'h0, rd, e, lat);
    chk("reinit_0031", 32'(rd), 32'h0000);
    access(1'b0, 1'b1, 1'b0, 16'h0032, 16'h0, rd, e, lat);
    chk("reinit_0032", 32'(rd), 32'h0000);
    access(1'b0, 1'b0, 1'b0, 16'h0008, 16'h0, rd, e, lat);
    chk("reinit_0008", 32'(rd), 32'hADEF);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

endmodule
